// File: rtl/hard_mem_1rw_arb_ctrl_pkg.sv
// Shared widths, request record and byte-to-bit mask helper for the
// two-requester 1RW SRAM arbiter.
package hard_mem_arb_pkg;
    localparam int num_req_gp    = 2;
    localparam int width_gp      = 32;
    localparam int els_gp        = 1024;
    localparam int addr_width_gp = $clog2(els_gp);
    localparam int mask_width_gp = width_gp / 8;

    typedef struct packed {
        logic                     w;
        logic [addr_width_gp-1:0] addr;
        logic [width_gp-1:0]      data;
        logic [mask_width_gp-1:0] mask;
    } req_s;

    function automatic logic [width_gp-1:0] mask_expand(input logic [mask_width_gp-1:0] byte_mask);
        logic [width_gp-1:0] bits;
        bits = '0;
        for (int b = 0; b < mask_width_gp; b++) begin
            bits[8*b +: 8] = {8{byte_mask[b]}};
        end
        return bits;
    endfunction
endpackage

// File: rtl/hard_mem_1rw_arb_ctrl_if.sv
// Requester, response and SRAM-macro signals of hard_mem_1rw_arb_ctrl;
// slave is the arbiter's view, master the surrounding system's.
interface hard_mem_1rw_arb_ctrl_if
    import hard_mem_arb_pkg::*;
#(
    parameter int width_p      = width_gp,
    parameter int addr_width_p = addr_width_gp,
    parameter int mask_width_p = mask_width_gp
);
    logic [num_req_gp-1:0]              req_v_i;
    logic [num_req_gp-1:0]              req_ready_o;
    logic [num_req_gp-1:0]              req_w_i;
    logic [num_req_gp*addr_width_p-1:0] req_addr_i;
    logic [num_req_gp*width_p-1:0]      req_data_i;
    logic [num_req_gp*mask_width_p-1:0] req_mask_i;
    logic [num_req_gp-1:0]              resp_v_o;
    logic [num_req_gp*width_p-1:0]      resp_data_o;
    logic [num_req_gp-1:0]              resp_yumi_i;
    logic                               mem_v_o;
    logic                               mem_w_o;
    logic [addr_width_p-1:0]            mem_addr_o;
    logic [width_p-1:0]                 mem_data_o;
    logic [width_p-1:0]                 mem_w_mask_o;
    logic [width_p-1:0]                 mem_data_i;

    modport slave (
        input  req_v_i, req_w_i, req_addr_i, req_data_i, req_mask_i, resp_yumi_i, mem_data_i,
        output req_ready_o, resp_v_o, resp_data_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_w_mask_o
    );

    modport master (
        output req_v_i, req_w_i, req_addr_i, req_data_i, req_mask_i, resp_yumi_i, mem_data_i,
        input  req_ready_o, resp_v_o, resp_data_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_w_mask_o
    );
endinterface

// File: rtl/hard_mem_1rw_arb_ctrl_rr2.sv
// Two-way round-robin arbiter; last_grant resets to port 1 so port 0 wins
// the first contention. No grants are issued while reset is held.
module hard_mem_arb_rr2 (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] v_i,
    output logic [1:0] grant_o
);
    logic r_last_grant;

    always_comb begin
        grant_o = 2'b00;
        if (!reset_i) begin
            if (v_i == 2'b11) grant_o = r_last_grant ? 2'b01 : 2'b10;
            else              grant_o = v_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)        r_last_grant <= 1'b1;
        else if (|grant_o)  r_last_grant <= grant_o[1];
    end
endmodule

// File: rtl/hard_mem_1rw_arb_ctrl.sv
// Shares one 1RW byte-masked SRAM macro between two requesters with one
// buffered read response per port. Define HARD_MEM_ARB_BYPASS_EN for 1-cycle reads.
module hard_mem_1rw_arb_ctrl
    import hard_mem_arb_pkg::*;
#(
    parameter int width_p      = width_gp,
    parameter int els_p        = els_gp,
    parameter int addr_width_p = addr_width_gp,
    parameter int mask_width_p = mask_width_gp
)
(
    input  logic                  clk_i,
    input  logic                  reset_i,
    hard_mem_1rw_arb_ctrl_if.slave bus
);
    // The request record is sized by the package, so overrides must agree with it.
    if ((width_p != width_gp) || (els_p != els_gp) || (addr_width_p != $clog2(els_p)) ||
        (mask_width_p != width_p / 8) || (width_p % 8 != 0)) begin : g_bad_params
        $error("hard_mem_1rw_arb_ctrl: parameters disagree with hard_mem_arb_pkg");
    end

    logic [num_req_gp-1:0] w_rd_ok;
    logic [num_req_gp-1:0] w_elig;
    logic [num_req_gp-1:0] w_grant;
    logic [num_req_gp-1:0] w_byp_take;
    logic [num_req_gp-1:0] r_inflight;
    logic [num_req_gp-1:0] r_buf_v;
    logic [width_p-1:0]    r_buf_data [num_req_gp];
    req_s                  w_req [num_req_gp];
    req_s                  w_sel;

`ifdef HARD_MEM_ARB_BYPASS_EN
    assign w_byp_take = r_inflight & bus.resp_yumi_i;
`else
    assign w_byp_take = '0;
`endif

    always_comb begin
        for (int p = 0; p < num_req_gp; p++) begin
            w_req[p].w    = bus.req_w_i[p];
            w_req[p].addr = bus.req_addr_i[p*addr_width_p +: addr_width_p];
            w_req[p].data = bus.req_data_i[p*width_p +: width_p];
            w_req[p].mask = bus.req_mask_i[p*mask_width_p +: mask_width_p];
            // a read needs a free response slot; a bypassed response frees it this cycle
            w_rd_ok[p]    = !r_buf_v[p] && (!r_inflight[p] || w_byp_take[p]);
            w_elig[p]     = bus.req_v_i[p] && (bus.req_w_i[p] || w_rd_ok[p]);
        end
    end

    hard_mem_arb_rr2 u_rr2 (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (w_elig),
        .grant_o (w_grant)
    );

    assign w_sel           = w_grant[1] ? w_req[1] : w_req[0];
    assign bus.req_ready_o = w_grant;

    always_comb begin
        bus.mem_v_o      = |w_grant;
        bus.mem_w_o      = 1'b0;
        bus.mem_addr_o   = '0;
        bus.mem_data_o   = '0;
        bus.mem_w_mask_o = '0;
        if (|w_grant) begin
            bus.mem_w_o    = w_sel.w;
            bus.mem_addr_o = w_sel.addr;
            bus.mem_data_o = w_sel.data;
            if (w_sel.w) bus.mem_w_mask_o = mask_expand(w_sel.mask);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_inflight <= '0;
            r_buf_v    <= '0;
            for (int p = 0; p < num_req_gp; p++) r_buf_data[p] <= '0;
        end else begin
            r_inflight <= w_grant & ~bus.req_w_i;
            for (int p = 0; p < num_req_gp; p++) begin
                if (r_inflight[p] && !w_byp_take[p]) begin
                    r_buf_v[p]    <= 1'b1;
                    r_buf_data[p] <= bus.mem_data_i;
                end else if (bus.resp_yumi_i[p]) begin
                    r_buf_v[p]    <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        bus.resp_v_o    = '0;
        bus.resp_data_o = '0;
        if (!reset_i) begin
            for (int p = 0; p < num_req_gp; p++) begin
                bus.resp_v_o[p]                    = r_buf_v[p];
                bus.resp_data_o[p*width_p +: width_p] = r_buf_data[p];
`ifdef HARD_MEM_ARB_BYPASS_EN
                if (r_inflight[p]) begin
                    bus.resp_v_o[p]                    = 1'b1;
                    bus.resp_data_o[p*width_p +: width_p] = bus.mem_data_i;
                end
`endif
            end
        end
    end
endmodule

// File: tb/tb_hard_mem_1rw_arb_ctrl.sv
// Bench for hard_mem_1rw_arb_ctrl: directed vector table, throughput and reset
// sequences, then random traffic against a transaction-level reference model.
module tb_hard_mem_1rw_arb_ctrl;
    import hard_mem_arb_pkg::*;

`ifdef HARD_MEM_ARB_BYPASS_EN
    localparam int resp_lat = 1;
`else
    localparam int resp_lat = 2;
`endif

    typedef struct {
        string       name;
        logic [31:0] v, w, y, a0, a1, d0, d1, m0, m1;
        logic [31:0] e_ready, e_mask, e_rv, e_r0, e_r1;
    } vec_t;

    logic clk_i = 1'b0;
    logic reset_i;
    int   checks = 0;
    int   failures = 0;
    vec_t tbl[$];

    logic [31:0] sram    [1024] = '{default: 32'h0};
    logic [31:0] ref_mem [1024] = '{default: 32'h0};

    // random-phase model state: a pending read per port and its age in cycles
    logic        m_pend [2];
    int          m_age  [2];
    logic [31:0] m_data [2];
    logic        m_last;
    logic [1:0]  r_v, r_w, r_y, r_elig, r_gnt, r_erv;
    logic [9:0]  r_a [2];
    logic [31:0] r_d [2];
    logic [3:0]  r_m [2];
    logic [31:0] bm;
    int          g;

    hard_mem_1rw_arb_ctrl_if bus ();

    hard_mem_1rw_arb_ctrl dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    // SRAM macro: masked write, read data valid the cycle after the access
    always @(posedge clk_i) begin
        if (bus.mem_v_o) begin
            if (bus.mem_w_o)
                sram[bus.mem_addr_o] <= (sram[bus.mem_addr_o] & ~bus.mem_w_mask_o) |
                                        (bus.mem_data_o & bus.mem_w_mask_o);
            else
                bus.mem_data_i <= sram[bus.mem_addr_o];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] expand4(input logic [3:0] m);
        logic [31:0] r;
        r = 32'h0;
        for (int b = 0; b < 4; b++) if (m[b]) r = r | (32'hFF << (8*b));
        return r;
    endfunction

    function automatic vec_t mk(input string n, input logic [31:0] v, w, y, a0, a1, d0, d1, m0, m1,
                                input logic [31:0] e_ready, e_mask, e_rv, e_r0, e_r1);
        vec_t t;
        t.name = n; t.v = v; t.w = w; t.y = y; t.a0 = a0; t.a1 = a1;
        t.d0 = d0; t.d1 = d1; t.m0 = m0; t.m1 = m1;
        t.e_ready = e_ready; t.e_mask = e_mask; t.e_rv = e_rv; t.e_r0 = e_r0; t.e_r1 = e_r1;
        return t;
    endfunction

    task automatic drive(input logic [1:0] v, w, y, input logic [9:0] a0, a1,
                         input logic [31:0] d0, d1, input logic [3:0] m0, m1);
        bus.req_v_i     = v;
        bus.req_w_i     = w;
        bus.resp_yumi_i = y;
        bus.req_addr_i  = {a1, a0};
        bus.req_data_i  = {d1, d0};
        bus.req_mask_i  = {m1, m0};
    endtask

    task automatic apply_vec(input vec_t t);
        int s;
        @(negedge clk_i);
        drive(t.v[1:0], t.w[1:0], t.y[1:0], t.a0[9:0], t.a1[9:0], t.d0, t.d1, t.m0[3:0], t.m1[3:0]);
        #1;
        chk({t.name, "/ready"}, 32'(bus.req_ready_o), t.e_ready);
        chk({t.name, "/mem_v"}, 32'(bus.mem_v_o), 32'(|t.e_ready));
        if (t.e_ready != 0) begin
            s = t.e_ready[1] ? 1 : 0;
            chk({t.name, "/mem_w"}, 32'(bus.mem_w_o), 32'(t.w[s]));
            chk({t.name, "/mem_addr"}, 32'(bus.mem_addr_o), (s == 1) ? t.a1 : t.a0);
            if (t.w[s]) begin
                chk({t.name, "/mem_mask"}, bus.mem_w_mask_o, t.e_mask);
                chk({t.name, "/mem_data"}, bus.mem_data_o, (s == 1) ? t.d1 : t.d0);
            end
        end
        chk({t.name, "/resp_v"}, 32'(bus.resp_v_o), t.e_rv);
        if (t.e_rv[0]) chk({t.name, "/resp0"}, bus.resp_data_o[31:0], t.e_r0);
        if (t.e_rv[1]) chk({t.name, "/resp1"}, bus.resp_data_o[63:32], t.e_r1);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk_i);
        reset_i = 1'b1;
        drive(2'b11, 2'b11, 2'b00, 10'h1, 10'h2, 32'h5, 32'h6, 4'hF, 4'hF);
        repeat (n) @(negedge clk_i);
        #1;
        chk("reset/mem_v", 32'(bus.mem_v_o), 0);
        chk("reset/ready", 32'(bus.req_ready_o), 0);
        chk("reset/resp_v", 32'(bus.resp_v_o), 0);
        chk("reset/mem_w", 32'(bus.mem_w_o), 0);
        reset_i = 1'b0;
        drive(2'b00, 2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    endtask

    initial begin
        reset_i = 1'b1;
        drive(2'b00, 2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0, 4'h0, 4'h0);
        do_reset(2);

`ifndef HARD_MEM_ARB_BYPASS_EN
        tbl.push_back(mk("wr_full",  1, 1, 0, 'h005, 0, 'hDEADBEEF, 0, 'hF, 0, 1, 'hFFFFFFFF, 0, 0, 0));
        tbl.push_back(mk("rd_005",   1, 0, 0, 'h005, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk("rd_lat1",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("rd_lat2",  0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'hDEADBEEF, 0));
        tbl.push_back(mk("rd_done",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("wr_ones",  2, 2, 0, 0, 'h3FF, 0, 'hFFFFFFFF, 0, 'hF, 2, 'hFFFFFFFF, 0, 0, 0));
        tbl.push_back(mk("wr_part",  2, 2, 0, 0, 'h3FF, 0, 'h11223344, 0, 'h5, 2, 'h00FF00FF, 0, 0, 0));
        tbl.push_back(mk("rd_3ff",   2, 0, 0, 0, 'h3FF, 0, 0, 0, 0, 2, 0, 0, 0, 0));
        tbl.push_back(mk("rd_3ff_w", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("rd_3ff_r", 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 'hFF22FF44));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk("alt", 3, 3, 0, 'h10, 'h20, 'hAAAA, 'hBBBB, 'hF, 'hF,
                             (i % 2 == 0) ? 1 : 2, 'hFFFFFFFF, 0, 0, 0));
        tbl.push_back(mk("hold_rd",  2, 0, 0, 0, 'h20, 0, 0, 0, 0, 2, 0, 0, 0, 0));
        tbl.push_back(mk("hold_inf", 2, 0, 0, 0, 'h20, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("hold_p0w", 3, 1, 0, 'h30, 'h20, 'h12345678, 0, 'hF, 0, 1, 'hFFFFFFFF, 2, 0, 'hBBBB));
        tbl.push_back(mk("hold_p1w", 2, 2, 0, 0, 'h21, 0, 'hCAFEF00D, 0, 'h3, 2, 'h0000FFFF, 2, 0, 'hBBBB));
        tbl.push_back(mk("hold_p0r", 3, 0, 0, 'h30, 'h20, 0, 0, 0, 0, 1, 0, 2, 0, 'hBBBB));
        tbl.push_back(mk("hold_blk", 3, 0, 0, 'h30, 'h20, 0, 0, 0, 0, 0, 0, 2, 0, 'hBBBB));
        tbl.push_back(mk("hold_two", 2, 0, 1, 0, 'h20, 0, 0, 0, 0, 0, 0, 3, 'h12345678, 'hBBBB));
        tbl.push_back(mk("hold_rel", 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 'hBBBB));
        tbl.push_back(mk("rd_21",    2, 0, 0, 0, 'h21, 0, 0, 0, 0, 2, 0, 0, 0, 0));
        tbl.push_back(mk("rd_21_w",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("rd_21_r",  0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 'h0000F00D));
        tbl.push_back(mk("idle",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`endif
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk("wr_seq", 1, 1, 0, i, 0, 'h100 + i, 0, 'hF, 0, 1, 'hFFFFFFFF, 0, 0, 0));
        foreach (tbl[i]) apply_vec(tbl[i]);

        // read accepted, then reset the next cycle: the response must vanish
        @(negedge clk_i);
        drive(2'b01, 2'b00, 2'b00, 10'h005, 10'h0, 32'h0, 32'h0, 4'h0, 4'h0);
        #1;
        chk("rst_mid/accept", 32'(bus.req_ready_o), 1);
        do_reset(1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            #1;
            chk("rst_mid/no_resp", 32'(bus.resp_v_o), 0);
        end
        apply_vec(mk("rst_mid/first", 3, 3, 0, 'h40, 'h41, 1, 2, 'hF, 'hF, 1, 'hFFFFFFFF, 0, 0, 0));

        // back-to-back reads on port 0 with an always-ready consumer
        for (int k = 0; k < 9; k++) begin
            @(negedge clk_i);
`ifdef HARD_MEM_ARB_BYPASS_EN
            drive({1'b0, k < 8}, 2'b00, {1'b0, k >= 1}, 10'(k), 10'h0, 32'h0, 32'h0, 4'h0, 4'h0);
            #1;
            chk("b2b/ready", 32'(bus.req_ready_o), (k < 8) ? 1 : 0);
            chk("b2b/resp_v", 32'(bus.resp_v_o), (k >= 1) ? 1 : 0);
            if (k >= 1) chk("b2b/resp0", bus.resp_data_o[31:0], 32'h100 + 32'(k - 1));
`else
            drive(2'b01, 2'b00, {1'b0, k % 3 == 2}, 10'(k / 3), 10'h0, 32'h0, 32'h0, 4'h0, 4'h0);
            #1;
            chk("b2b/ready", 32'(bus.req_ready_o), (k % 3 == 0) ? 1 : 0);
            chk("b2b/resp_v", 32'(bus.resp_v_o), (k % 3 == 2) ? 1 : 0);
            if (k % 3 == 2) chk("b2b/resp0", bus.resp_data_o[31:0], 32'h100 + 32'(k / 3));
`endif
        end

        // random traffic in 0x200..0x20F against the reference model
        do_reset(2);
        m_last = 1'b1;
        for (int p = 0; p < 2; p++) begin m_pend[p] = 1'b0; m_age[p] = 0; m_data[p] = 32'h0; end
        for (int c = 0; c < 600; c++) begin
            @(negedge clk_i);
            r_v = 2'($urandom_range(0, 3));
            r_w = 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++) begin
                r_erv[p] = m_pend[p] && (m_age[p] >= resp_lat);
                r_y[p]   = r_erv[p] && ($urandom_range(0, 3) != 0);
                r_a[p]   = 10'h200 + 10'($urandom_range(0, 15));
                r_d[p]   = $urandom;
                r_m[p]   = 4'($urandom_range(0, 15));
                r_elig[p] = r_v[p] && (r_w[p] || !m_pend[p] ||
                                       (resp_lat == 1 && m_age[p] == 1 && r_y[p]));
            end
            if (r_elig == 2'b11) r_gnt = m_last ? 2'b01 : 2'b10;
            else                 r_gnt = r_elig;
            drive(r_v, r_w, r_y, r_a[0], r_a[1], r_d[0], r_d[1], r_m[0], r_m[1]);
            #1;
            chk("rand/ready", 32'(bus.req_ready_o), 32'(r_gnt));
            chk("rand/mem_v", 32'(bus.mem_v_o), 32'(|r_gnt));
            g = r_gnt[1] ? 1 : 0;
            if (r_gnt != 2'b00) begin
                chk("rand/mem_addr", 32'(bus.mem_addr_o), 32'(r_a[g]));
                chk("rand/mem_w", 32'(bus.mem_w_o), 32'(r_w[g]));
                if (r_w[g]) begin
                    chk("rand/mem_mask", bus.mem_w_mask_o, expand4(r_m[g]));
                    chk("rand/mem_data", bus.mem_data_o, r_d[g]);
                end
            end
            chk("rand/resp_v", 32'(bus.resp_v_o), 32'(r_erv));
            if (r_erv[0]) chk("rand/resp0", bus.resp_data_o[31:0], m_data[0]);
            if (r_erv[1]) chk("rand/resp1", bus.resp_data_o[63:32], m_data[1]);
            if (r_gnt != 2'b00) m_last = r_gnt[1];
            for (int p = 0; p < 2; p++) begin
                if (m_pend[p] && r_erv[p] && r_y[p]) m_pend[p] = 1'b0;
                else if (m_pend[p])                  m_age[p]++;
            end
            if (r_gnt != 2'b00) begin
                if (r_w[g]) begin
                    bm = expand4(r_m[g]);
                    ref_mem[r_a[g]] = (ref_mem[r_a[g]] & ~bm) | (r_d[g] & bm);
                end else begin
                    m_pend[g] = 1'b1;
                    m_age[g]  = 1;
                    m_data[g] = ref_mem[r_a[g]];
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
